// File: rtl/wb_interconnect_if.sv
// Bus bundle for the single-master Wishbone (pipelined) interconnect.
// The "slave" modport is the interconnect's own view: it receives the
// cpu request and the slave responses and drives everything else.
// The "master" modport is the view of the surrounding system (cpu plus
// the attached slaves), which drives the interconnect's inputs.
interface wb_interconnect_if #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NSLAVES = 3
);
   // cpu side
   logic                    i_wb_cyc;
   logic                    i_wb_stb;
   logic                    i_wb_we;
   logic [AW-1:0]           i_wb_addr;
   logic [DW-1:0]           i_wb_data;
   logic [DW-1:0]           o_wb_data;
   logic                    o_wb_ack;
   logic                    o_wb_stall;
   logic                    o_wb_err;
   // slave side
   logic [NSLAVES-1:0]      o_s_cyc;
   logic [NSLAVES-1:0]      o_s_stb;
   logic                    o_s_we;
   logic [AW-1:0]           o_s_addr;
   logic [DW-1:0]           o_s_data;
   logic [NSLAVES*DW-1:0]   i_s_data;
   logic [NSLAVES-1:0]      i_s_ack;
   logic [NSLAVES-1:0]      i_s_stall;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output i_s_data, i_s_ack, i_s_stall,
      input  o_wb_data, o_wb_ack, o_wb_stall, o_wb_err,
      input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  i_s_data, i_s_ack, i_s_stall,
      output o_wb_data, o_wb_ack, o_wb_stall, o_wb_err,
      output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data
   );
endinterface

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone (pipelined) address decoder/router.
// Each slave owns a base/mask window; the lowest-index window wins on
// overlap. Up to MAX_OUTSTANDING requests may be in flight to the one
// locked slave; a request to any other slave waits until all responses
// have drained. Unmapped requests end with a one-cycle bus error.
// Optional ack watchdog: define WB_TIMEOUT_EN to abort a transfer whose
// slave stays silent for TIMEOUT_CYCLES cycles while busy.
module wb_interconnect #(
   parameter int                       AW              = 32,
   parameter int                       DW              = 32,
   parameter int                       NSLAVES         = 3,
   parameter logic [NSLAVES*AW-1:0]    SLAVE_BASE      = {32'hc0000000, 32'hb0008000, 32'hb0000000},
   parameter logic [NSLAVES*AW-1:0]    SLAVE_MASK      = {32'hffff0000, 32'hffff8000, 32'hffff8000},
   parameter int                       MAX_OUTSTANDING = 4,
   parameter int                       TIMEOUT_CYCLES  = 255
) (
   input  logic               clk,
   input  logic               reset,
   wb_interconnect_if.slave   bus
);
   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_OUTSTANDING);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   logic [1:0]          state_reg, state_next;
   logic [SW-1:0]       sel_reg, sel_next;
   logic [CW-1:0]       count_reg, count_next;

   logic [NSLAVES-1:0]  hit;
   logic [SW-1:0]       hit_idx;
   logic                miss;
   logic                req;
   logic                accept;
   logic                ack_in;
   logic                wd_expire;
   logic [NSLAVES-1:0]  stb_vec;
   logic [NSLAVES-1:0]  cyc_vec;
   logic                stall;
   logic                err;

   // Address window match for every slave.
   generate
      for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_decode
         assign hit[gi] = ((bus.i_wb_addr & SLAVE_MASK[gi*AW +: AW]) == SLAVE_BASE[gi*AW +: AW]);
      end
   endgenerate

   // Priority encode the hits so that the lowest index wins on overlap.
   always_comb begin
      hit_idx = '0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = SW'(i);
      end
   end

   assign miss = ~|hit;
   assign req  = bus.i_wb_cyc & bus.i_wb_stb;

`ifdef WB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0] wd_reg;

   // The abort fires in the last silent busy cycle; an ack in that very
   // cycle still counts as progress and cancels it.
   assign wd_expire = (state_reg == ST_BUSY) && (wd_reg == WD_LIMIT) && !bus.i_s_ack[sel_reg];

   // Watchdog: restarts on each ack from the locked slave, runs while busy.
   always_ff @(posedge clk) begin
      if (reset || state_reg != ST_BUSY || ack_in) begin
         wd_reg <= '0;
      end else begin
         wd_reg <= wd_reg + WW'(1);
      end
   end
`else
   assign wd_expire = 1'b0;
`endif

   // Next-state, strobe routing, stall and outstanding-count bookkeeping.
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      count_next = count_reg;
      stb_vec    = '0;
      cyc_vec    = '0;
      stall      = 1'b0;
      err        = 1'b0;
      accept     = 1'b0;
      ack_in     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            count_next = '0;
            if (req) begin
               if (!miss) begin
                  // Present to the decoded slave; lock it once it takes the strobe.
                  stb_vec[hit_idx] = 1'b1;
                  cyc_vec[hit_idx] = 1'b1;
                  stall            = bus.i_s_stall[hit_idx];
                  sel_next         = hit_idx;
                  if (!bus.i_s_stall[hit_idx]) begin
                     count_next = CW'(1);
                     state_next = ST_BUSY;
                  end
               end else begin
                  // Unmapped: swallow the request and answer with an error.
                  state_next = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            cyc_vec[sel_reg] = bus.i_wb_cyc;
            ack_in           = bus.i_s_ack[sel_reg];
            if (req) begin
               if (!miss && hit_idx == sel_reg && count_reg < COUNT_MAX && !wd_expire) begin
                  stb_vec[sel_reg] = 1'b1;
                  stall            = bus.i_s_stall[sel_reg];
                  accept           = ~bus.i_s_stall[sel_reg];
               end else begin
                  // Other slave, unmapped or pipeline full: hold off until drained.
                  stall = 1'b1;
               end
            end
            count_next = count_reg + CW'(accept) - CW'(ack_in);
            if (!bus.i_wb_cyc) begin
               count_next = '0;
               state_next = ST_IDLE;
            end else if (wd_expire) begin
               count_next = '0;
               state_next = ST_ERR;
            end else if (count_next == '0) begin
               state_next = ST_IDLE;
            end
         end
         ST_ERR: begin
            err        = 1'b1;
            stall      = req;
            count_next = '0;
            state_next = ST_IDLE;
         end
         default: begin
            count_next = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, locked slave and outstanding count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         sel_reg   <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         count_reg <= count_next;
      end
   end

   // Response path and broadcast request signals.
   assign bus.o_wb_ack   = (state_reg == ST_BUSY) && bus.i_s_ack[sel_reg] && (count_reg != '0);
   assign bus.o_wb_data  = bus.i_s_data[sel_reg*DW +: DW];
   assign bus.o_wb_err   = err;
   assign bus.o_wb_stall = stall;
   assign bus.o_s_cyc    = cyc_vec;
   assign bus.o_s_stb    = stb_vec;
   assign bus.o_s_we     = bus.i_wb_we;
   assign bus.o_s_addr   = bus.i_wb_addr;
   assign bus.o_s_data   = bus.i_wb_data;
endmodule

// File: tb/tb_wb_interconnect.sv
// Testbench for wb_interconnect: directed scenarios followed by randomized
// single transactions checked against an address-window reference model.
// The WB_TIMEOUT_EN scenario runs only when that macro is defined.
module tb_wb_interconnect;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_interconnect_if #(.AW(32), .DW(32), .NSLAVES(3)) bus ();

   wb_interconnect #(
      .AW(32), .DW(32), .NSLAVES(3),
      .SLAVE_BASE({32'hc0000000, 32'hb0008000, 32'hb0000000}),
      .SLAVE_MASK({32'hffff0000, 32'hffff8000, 32'hffff8000}),
      .MAX_OUTSTANDING(4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference address map: first matching window wins, -1 when unmapped.
   function automatic int ref_decode(input logic [31:0] a);
      if ((a & 32'hffff8000) == 32'hb0000000) return 0;
      if ((a & 32'hffff8000) == 32'hb0008000) return 1;
      if ((a & 32'hffff0000) == 32'hc0000000) return 2;
      return -1;
   endfunction

   function automatic logic [31:0] win_base(input int k);
      case (k)
         0:       return 32'hb0000000;
         1:       return 32'hb0008000;
         default: return 32'hc0000000;
      endcase
   endfunction

   function automatic logic [31:0] win_span(input int k);
      return (k == 2) ? 32'h0000ffff : 32'h00007fff;
   endfunction

   function automatic logic [2:0] onehot(input int k);
      return (k < 0) ? 3'b000 : 3'(1 << k);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_sdata(input int k, input logic [31:0] d);
      bus.i_s_data[k*32 +: 32] = d;
   endtask

   task automatic idle_inputs();
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = '0;
      bus.i_wb_data = '0;
      bus.i_s_data  = '0;
      bus.i_s_ack   = '0;
      bus.i_s_stall = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [31:0] a, d, rd;
      logic        w;
      int          k, exp_k, ns, nw;
`ifdef WB_TIMEOUT_EN
      int          n;
      bit          seen;
`endif

      // Reset state.
      idle_inputs();
      reset = 1'b1;
      repeat (2) next_cycle();
      sample();
      check("rst_ack",   bus.o_wb_ack, 0);
      check("rst_err",   bus.o_wb_err, 0);
      check("rst_stall", bus.o_wb_stall, 0);
      check("rst_scyc",  bus.o_s_cyc, 0);
      check("rst_sstb",  bus.o_s_stb, 0);
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Read from slave 0, ack one cycle later.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
      bus.i_wb_addr = 32'hb0000010;
      sample();
      check("rd0_stb",   bus.o_s_stb, 3'b001);
      check("rd0_scyc",  bus.o_s_cyc, 3'b001);
      check("rd0_stall", bus.o_wb_stall, 0);
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_s_ack = 3'b001; set_sdata(0, 32'hdeadbeef);
      sample();
      check("rd0_ack",   bus.o_wb_ack, 1);
      check("rd0_data",  bus.o_wb_data, 32'hdeadbeef);
      check("rd0_nostb", bus.o_s_stb, 0);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      sample();
      check("rd0_ackoff", bus.o_wb_ack, 0);
      next_cycle();

      // Write to slave 1.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
      bus.i_wb_addr = 32'hb0008004; bus.i_wb_data = 32'h12345678;
      sample();
      check("wr1_stb",  bus.o_s_stb, 3'b010);
      check("wr1_we",   bus.o_s_we, 1);
      check("wr1_data", bus.o_s_data, 32'h12345678);
      check("wr1_addr", bus.o_s_addr, 32'hb0008004);
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0; bus.i_s_ack = 3'b010; set_sdata(1, 32'hcafef00d);
      sample();
      check("wr1_ack",   bus.o_wb_ack, 1);
      check("wr1_rdata", bus.o_wb_data, 32'hcafef00d);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      next_cycle();

      // Unmapped access.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'ha0000000;
      sample();
      check("um_stb",   bus.o_s_stb, 0);
      check("um_stall", bus.o_wb_stall, 0);
      check("um_err0",  bus.o_wb_err, 0);
      next_cycle();
      bus.i_wb_stb = 1'b0;
      sample();
      check("um_err1", bus.o_wb_err, 1);
      check("um_ack",  bus.o_wb_ack, 0);
      next_cycle();
      bus.i_wb_cyc = 1'b0;
      sample();
      check("um_err2", bus.o_wb_err, 0);
      next_cycle();

      // Five pipelined reads to slave 1 with acks withheld.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.i_wb_addr = 32'hb0008000 + 32'(4 * i);
         sample();
         check("pipe_stall", bus.o_wb_stall, 0);
         check("pipe_stb",   bus.o_s_stb, 3'b010);
         next_cycle();
      end
      bus.i_wb_addr = 32'hb0008010;
      repeat (2) begin
         sample();
         check("full_stall", bus.o_wb_stall, 1);
         check("full_stb",   bus.o_s_stb, 0);
         next_cycle();
      end
      bus.i_s_ack = 3'b010;
      sample();
      check("full_ack",   bus.o_wb_ack, 1);
      check("full_stall", bus.o_wb_stall, 1);
      next_cycle();
      bus.i_s_ack = 3'b000;
      sample();
      check("fifth_stall", bus.o_wb_stall, 0);
      check("fifth_stb",   bus.o_s_stb, 3'b010);
      next_cycle();
      bus.i_wb_stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.i_s_ack = 3'b010;
         sample();
         check("drain_ack", bus.o_wb_ack, 1);
         next_cycle();
      end
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      sample();
      check("drain_idle", bus.o_wb_ack, 0);
      next_cycle();

      // Slave switch waits for the outstanding read; spurious ack ignored.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0000020;
      sample();
      check("sw_stb0", bus.o_s_stb, 3'b001);
      next_cycle();
      bus.i_wb_addr = 32'hc0000000; bus.i_s_ack = 3'b100;
      sample();
      check("sw_stall", bus.o_wb_stall, 1);
      check("sw_nostb", bus.o_s_stb, 0);
      check("sw_spur",  bus.o_wb_ack, 0);
      next_cycle();
      bus.i_s_ack = 3'b001; set_sdata(0, 32'h11112222);
      sample();
      check("sw_ack0",   bus.o_wb_ack, 1);
      check("sw_data0",  bus.o_wb_data, 32'h11112222);
      check("sw_stall2", bus.o_wb_stall, 1);
      next_cycle();
      bus.i_s_ack = 3'b000;
      sample();
      check("sw_stb2",   bus.o_s_stb, 3'b100);
      check("sw_scyc2",  bus.o_s_cyc, 3'b100);
      check("sw_go",     bus.o_wb_stall, 0);
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_s_ack = 3'b100; set_sdata(2, 32'h33334444);
      sample();
      check("sw_ack2",  bus.o_wb_ack, 1);
      check("sw_data2", bus.o_wb_data, 32'h33334444);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      next_cycle();

      // Master drops cyc mid-transfer; the late ack must be ignored.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0000000;
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_wb_cyc = 1'b0;
      sample();
      check("drop_scyc", bus.o_s_cyc, 0);
      next_cycle();
      bus.i_s_ack = 3'b001;
      sample();
      check("drop_late", bus.o_wb_ack, 0);
      next_cycle();
      bus.i_s_ack = 3'b000;
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0008000;
      sample();
      check("drop_next", bus.o_s_stb, 3'b010);
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_s_ack = 3'b010;
      sample();
      check("drop_ack", bus.o_wb_ack, 1);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      next_cycle();

      // Reset while busy.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0008040;
      next_cycle();
      bus.i_wb_stb = 1'b0; reset = 1'b1;
      sample();
      check("mrst_busy", bus.o_s_cyc, 3'b010);
      next_cycle();
      reset = 1'b0; bus.i_s_ack = 3'b010;
      sample();
      check("mrst_scyc", bus.o_s_cyc, 0);
      check("mrst_sstb", bus.o_s_stb, 0);
      check("mrst_ack",  bus.o_wb_ack, 0);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      next_cycle();

`ifdef WB_TIMEOUT_EN
      // Silent slave: error pulse eight cycles after acceptance.
      bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0000100;
      next_cycle();
      bus.i_wb_stb = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 50) begin
         sample();
         if (bus.o_wb_err) begin
            seen = 1'b1;
         end else begin
            next_cycle();
            n++;
         end
      end
      check("to_cycles", n, 8);
      check("to_scyc",   bus.o_s_cyc, 0);
      check("to_ack",    bus.o_wb_ack, 0);
      next_cycle();
      bus.i_wb_stb = 1'b1; bus.i_wb_addr = 32'hb0008008;
      sample();
      check("to_next", bus.o_s_stb, 3'b010);
      next_cycle();
      bus.i_wb_stb = 1'b0; bus.i_s_ack = 3'b010;
      sample();
      check("to_nack", bus.o_wb_ack, 1);
      next_cycle();
      bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
      next_cycle();
`endif

      // Randomized single transactions against the address-map model.
      for (int t = 0; t < 40; t++) begin
         k  = $urandom_range(0, 3);
         w  = 1'($urandom);
         d  = $urandom;
         ns = $urandom_range(0, 2);
         nw = $urandom_range(0, 3);
         if (k == 3) begin
            a = $urandom;
            while (ref_decode(a) != -1) a = $urandom;
         end else begin
            a = win_base(k) | ($urandom & win_span(k));
         end
         exp_k = ref_decode(a);
         bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = w;
         bus.i_wb_addr = a; bus.i_wb_data = d;
         if (exp_k < 0) begin
            sample();
            check("rnd_um_stb",   bus.o_s_stb, 0);
            check("rnd_um_stall", bus.o_wb_stall, 0);
            next_cycle();
            bus.i_wb_stb = 1'b0;
            sample();
            check("rnd_um_err", bus.o_wb_err, 1);
            check("rnd_um_ack", bus.o_wb_ack, 0);
            next_cycle();
            bus.i_wb_cyc = 1'b0;
            rd = 32'h0;
         end else begin
            for (int s = 0; s < ns; s++) begin
               bus.i_s_stall = onehot(exp_k) | 3'($urandom);
               sample();
               check("rnd_stall_hi", bus.o_wb_stall, 1);
               check("rnd_stall_stb", bus.o_s_stb, onehot(exp_k));
               next_cycle();
            end
            bus.i_s_stall = 3'($urandom) & ~onehot(exp_k);
            sample();
            check("rnd_stb",   bus.o_s_stb, onehot(exp_k));
            check("rnd_stall", bus.o_wb_stall, 0);
            check("rnd_addr",  bus.o_s_addr, a);
            check("rnd_we",    bus.o_s_we, w);
            check("rnd_wdata", bus.o_s_data, d);
            next_cycle();
            bus.i_wb_stb = 1'b0; bus.i_s_stall = 3'b000;
            for (int s = 0; s < nw; s++) begin
               bus.i_s_ack = 3'($urandom) & ~onehot(exp_k);
               sample();
               check("rnd_noack", bus.o_wb_ack, 0);
               next_cycle();
            end
            rd = $urandom;
            bus.i_s_data = {$urandom, $urandom, $urandom};
            set_sdata(exp_k, rd);
            bus.i_s_ack = onehot(exp_k) | 3'($urandom);
            sample();
            check("rnd_ack",   bus.o_wb_ack, 1);
            check("rnd_rdata", bus.o_wb_data, rd);
            check("rnd_noerr", bus.o_wb_err, 0);
            next_cycle();
            bus.i_s_ack = 3'b000; bus.i_wb_cyc = 1'b0;
         end
         $display("txn %0d addr=%08h we=%0b wdata=%08h slave=%0d rdata=%08h", t, a, w, d, exp_k, rd);
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Single-master, N-slave Wishbone (pipelined mode) address decoder/router between the cpu core and memories/peripherals (bootrom, internal SRAM, IO).
- Replaces ad-hoc combinational enable decoding with parametrised base/mask windows, outstanding-transaction tracking, and per-slave response routing.
- Unmapped accesses terminate with a bus-error pulse, never with a hung bus or a latch.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- NSLAVES, 3, number of slave channels (1..8).
- SLAVE_BASE, {32'hc0000000, 32'hb0008000, 32'hb0000000}, packed NSLAVES*AW base addresses; slave 0 in LSBs.
- SLAVE_MASK, {32'hffff0000, 32'hffff8000, 32'hffff8000}, packed NSLAVES*AW masks; hit when (addr & mask) == base.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests (power of two, >=1).
- TIMEOUT_CYCLES, 255, ack timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  master cycle
- i_wb_stb  in  1  master strobe
- i_wb_we  in  1  master write enable
- i_wb_addr  in  AW  master byte address
- i_wb_data  in  DW  master write data
- o_wb_data  out  DW  read data to master
- o_wb_ack  out  1  ack to master
- o_wb_stall  out  1  stall to master
- o_wb_err  out  1  bus error to master
- o_s_cyc  out  NSLAVES  per-slave cycle
- o_s_stb  out  NSLAVES  per-slave strobe
- o_s_we  out  1  broadcast write enable
- o_s_addr  out  AW  broadcast address
- o_s_data  out  DW  broadcast write data
- i_s_data  in  NSLAVES*DW  packed slave read data
- i_s_ack  in  NSLAVES  slave acks
- i_s_stall  in  NSLAVES  slave stalls

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, outstanding count=0, sel=0, o_wb_err=0. o_wb_ack, o_s_cyc and o_s_stb evaluate to 0. o_wb_stall=0.
- Decode (combinational): hit[i] = ((i_wb_addr & MASK[i]) == BASE[i]). Lowest index wins on overlap. miss = no hit.
- Pass-through: o_s_we, o_s_addr and o_s_data are combinational copies of the master signals.
- States:
  - IDLE: count=0.
  - BUSY: count>0, slave sel locked.
  - ERR: one-cycle error response.
- IDLE + cyc&stb & hit[k]: sel<=k, o_s_stb[k]=1. The request is accepted when ~i_s_stall[k]: count<=1, go to BUSY.
- IDLE + cyc&stb & miss: o_wb_stall=0, no slave strobed, go to ERR. In ERR, o_wb_err=1 for exactly one cycle, then IDLE.
- BUSY, new stb:
  - Same slave (hit[sel]) and count<MAX_OUTSTANDING: forwarded; o_wb_stall=i_s_stall[sel].
  - Different slave, miss, or count==MAX_OUTSTANDING: o_wb_stall=1, no slave strobed until the count drains to 0.
- Counter:
  - +1 on accepted strobe (stb&~stall to a slave).
  - -1 on i_s_ack[sel].
  - Both in the same cycle: unchanged.
  - Ack when count==0: ignored.
  - Count reaching 0 with no new request: return to IDLE.
- Response: o_wb_ack = i_s_ack[sel] & (count>0), combinational. o_wb_data = i_s_data slice [sel], combinational. Acks from non-selected slaves are ignored.
- o_s_cyc[sel] = i_wb_cyc while BUSY or while a strobe is presented to sel; 0 for all other slaves.
- Master drops cyc mid-transfer: count<=0, state<=IDLE next cycle, all o_s_cyc=0; late slave acks are ignored.
- Reset mid-transfer: same as the reset values above, next edge.
- o_wb_err and o_wb_ack are never asserted in the same cycle.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - A watchdog counter clears on every slave ack and increments each cycle while BUSY.
  - On reaching TIMEOUT_CYCLES, the transfer aborts: o_wb_err=1 for one cycle, count<=0, o_s_cyc=0, go to IDLE.
- Not defined: no watchdog logic; BUSY waits indefinitely for acks.

Test Plan:
- Read addr 0xb0000010, slave0 acks 1 cycle later with data 0xdeadbeef -> o_s_stb=3'b001 one cycle; o_wb_ack=1 with o_wb_data=0xdeadbeef; count returns to 0.
- Write 0xb0008004 data 0x12345678 -> o_s_stb=3'b010, o_s_we=1, o_s_data=0x12345678; ack routed back; slave0 and slave2 strobes stay 0.
- Access 0xa0000000 -> no slave strobe; o_wb_err=1 exactly one cycle later; o_wb_ack stays 0.
- 5 back-to-back reads to slave1 with acks withheld -> 4 accepted; 5th stalled (o_wb_stall=1) until first ack; then accepted.
- Outstanding read to slave0, then request to 0xc0000000 -> stalled until slave0 ack; then forwarded to slave2. Also: a spurious i_s_ack[2] during the wait is ignored.
- Under WB_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never acks -> o_wb_err pulse at cycle 8 after acceptance; o_s_cyc=0; next request decoded normally. Also: reset asserted mid-BUSY clears count and all strobes on the next edge.
